// File: rtl/imem_fetch_controller_pkg.sv
// Shared constants and FSM state encoding for the instruction memory fetch controller.
package imem_ctrl_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_WR = 2'd1,
        RUN     = 2'd2,
        DRAIN   = 2'd3
    } state_t;

endpackage

// File: rtl/imem_fetch_out_reg.sv
// One-entry valid/ready output register holding the fetched word and its address.
// A flush drops the held word; it wins over a simultaneous push.
module fetch_out_reg #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              ready,
    output logic              vld,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] pc,
    output logic              space
);

    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic [ADDR_W-1:0] pc_p0;

    // Output stage: capture a new word on push, drop the held word on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            pc_p0   <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (push) begin
            vld_p0  <= 1'b1;
            data_p0 <= push_data;
            pc_p0   <= push_pc;
        end
    end

    assign vld   = vld_p0;
    assign data  = data_p0;
    assign pc    = pc_p0;
    // The register can take a new word when empty or when the held word leaves this cycle.
    assign space = !vld_p0 || ready;

endmodule

// File: rtl/imem_fetch_controller.sv
// Sequences the single instruction memory port between the boot loader (writes)
// and the fetch path (reads), delivering words to decode over valid/ready.
module imem_fetch_controller
    import imem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t state;
    logic   out_space;
    logic   fetching;
    logic   redirect_take;
    logic   push;
    logic   flush;

    assign load_ready    = (state == IDLE);
    assign fetching      = (state == RUN) || (state == DRAIN);
    assign redirect_take = fetching && redirect_valid;
    assign push          = (state == RUN) && !redirect_valid && out_space;
    assign flush         = redirect_take || ((state == DRAIN) && inst_valid && inst_ready);

    // Control FSM: owns the memory port (address, direction, write data) and the halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_rd    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
        end else begin
            mem_rd <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (load_valid) begin
                        mem_addr  <= load_addr;
                        mem_wdata <= load_data;
                        mem_rd    <= 1'b0;
                        state     <= LOAD_WR;
                    end else if (start) begin
                        mem_addr <= start_addr;
                        halted   <= 1'b0;
                        state    <= RUN;
                    end
                end
                LOAD_WR: begin
                    state <= IDLE;
                end
                RUN: begin
                    if (redirect_valid) begin
                        mem_addr <= redirect_addr;
                    end else if (out_space) begin
                        // The last word holds the address instead of wrapping to 0.
                        if (mem_addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        mem_addr <= redirect_addr;
                        state    <= RUN;
                    end else if (inst_valid && inst_ready) begin
                        halted <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_out_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (mem_rdata),
        .push_pc   (mem_addr),
        .ready     (inst_ready),
        .vld       (inst_valid),
        .data      (inst_data),
        .pc        (inst_pc),
        .space     (out_space)
    );

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Bench for imem_fetch_controller: directed scenarios plus randomized fetch
// episodes checked against a stream-level model of the expected instruction sequence.
module tb_imem_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [6:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic [6:0]  start_addr;
    logic        redirect_valid;
    logic [6:0]  redirect_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [6:0]  inst_pc;
    logic        halted;
    logic [6:0]  mem_addr;
    logic        mem_rd;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [128];
    logic [31:0] ref_mem [128];
    int          wr_pulses = 0;

    always #5 clk = ~clk;

    // Level-sensitive memory: combinational read, write while mem_rd is low.
    always @(posedge clk) begin
        if (mem_rd === 1'b0) begin
            mem[mem_addr] <= mem_wdata;
            wr_pulses     <= wr_pulses + 1;
        end
    end
    assign mem_rdata = mem[mem_addr];

    imem_fetch_controller dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .start          (start),
        .start_addr     (start_addr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .halted         (halted),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [6:0] a, input logic [31:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        tick();
        load_valid = 1'b0;
        tick();
        ref_mem[a] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; start_addr = '0; redirect_valid = 1'b0; redirect_addr = '0;
        inst_ready = 1'b0;
        tick(); tick();
        total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL reset_mem_rd got=%0d exp=1", mem_rd); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%0d exp=0", inst_valid); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready got=%0d exp=1", load_ready); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0d exp=0", halted); end
        total++; if (mem_addr !== 7'd0 || inst_pc !== 7'd0 || inst_data !== 32'd0 || mem_wdata !== 32'd0) begin
            bad++; $display("FAIL reset_regs got addr=%0d pc=%0d data=%h wdata=%h exp all 0", mem_addr, inst_pc, inst_data, mem_wdata);
        end
        rst = 1'b0;
        load_valid = 1'b1; load_addr = 7'd9; load_data = 32'hABCD0123;
        tick();
        load_valid = 1'b0;
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_prep_write got mem_rd=%0d exp=0", mem_rd); end
        rst = 1'b1;
        tick();
        total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL midwr_mem_rd got=%0d exp=1", mem_rd); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL midwr_inst_valid got=%0d exp=0", inst_valid); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL midwr_load_ready got=%0d exp=1", load_ready); end
        total++; if (halted !== 1'b0 || mem_addr !== 7'd0 || mem_wdata !== 32'd0) begin
            bad++; $display("FAIL midwr_regs got halted=%0d addr=%0d wdata=%h exp 0", halted, mem_addr, mem_wdata);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_load();
        int          w0;
        logic [31:0] d;
        w0 = wr_pulses;
        for (int i = 0; i < 3; i++) begin
            d = 32'h11111111 * (i + 1);
            load_valid = 1'b1; load_addr = 7'(i); load_data = d;
            total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL load_ready_idle[%0d] got=%0d exp=1", i, load_ready); end
            tick();
            load_valid = 1'b0;
            total++; if (mem_rd !== 1'b0 || mem_addr !== 7'(i) || mem_wdata !== d) begin
                bad++; $display("FAIL load_write[%0d] got rd=%0d addr=%0d data=%h exp rd=0 addr=%0d data=%h", i, mem_rd, mem_addr, mem_wdata, i, d);
            end
            total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL load_ready_wr[%0d] got=%0d exp=0", i, load_ready); end
            tick();
            total++; if (mem_rd !== 1'b1 || load_ready !== 1'b1) begin
                bad++; $display("FAIL load_back[%0d] got rd=%0d ready=%0d exp 1/1", i, mem_rd, load_ready);
            end
            ref_mem[i] = d;
        end
        for (int i = 3; i < 128; i++) do_load(7'(i), $urandom);
        total++; if (wr_pulses - w0 !== 128) begin bad++; $display("FAIL load_pulse_count got=%0d exp=128", wr_pulses - w0); end
    endtask

    task automatic test_fetch();
        start = 1'b1; start_addr = 7'd0; inst_ready = 1'b1;
        tick();
        start = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fetch_lat1 got valid=%0d exp=0", inst_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (inst_valid !== 1'b1 || inst_pc !== 7'(i) || inst_data !== ref_mem[i]) begin
                bad++; $display("FAIL fetch_word[%0d] got v=%0d pc=%0d d=%h exp v=1 pc=%0d d=%h", i, inst_valid, inst_pc, inst_data, i, ref_mem[i]);
            end
        end
        total++; if (halted !== 1'b0 || mem_rd !== 1'b1) begin bad++; $display("FAIL fetch_flags got halted=%0d rd=%0d exp 0/1", halted, mem_rd); end
    endtask

    task automatic test_stall();
        redirect_valid = 1'b1; redirect_addr = 7'd0;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 7'd0) begin bad++; $display("FAIL stall_pre0 got v=%0d pc=%0d exp 1/0", inst_valid, inst_pc); end
        tick();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 7'd1) begin bad++; $display("FAIL stall_pre1 got v=%0d pc=%0d exp 1/1", inst_valid, inst_pc); end
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (inst_valid !== 1'b1 || inst_pc !== 7'd1 || inst_data !== ref_mem[1]) begin
                bad++; $display("FAIL stall_hold[%0d] got v=%0d pc=%0d d=%h exp v=1 pc=1 d=%h", i, inst_valid, inst_pc, inst_data, ref_mem[1]);
            end
        end
        inst_ready = 1'b1;
        tick();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 7'd2 || inst_data !== ref_mem[2]) begin
            bad++; $display("FAIL stall_release got v=%0d pc=%0d d=%h exp v=1 pc=2 d=%h", inst_valid, inst_pc, inst_data, ref_mem[2]);
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (inst_valid === 1'b1 && inst_pc === 7'd5) found = 1;
            else tick();
        end
        total++; if (!found) begin bad++; $display("FAIL redir_reach_pc5 got pc=%0d exp=5 (timeout)", inst_pc); end
        redirect_valid = 1'b1; redirect_addr = 7'h40;
        tick();
        redirect_valid = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got valid=%0d exp=0", inst_valid); end
        tick();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 7'h40 || inst_data !== ref_mem[64]) begin
            bad++; $display("FAIL redir_target got v=%0d pc=%0d d=%h exp v=1 pc=64 d=%h", inst_valid, inst_pc, inst_data, ref_mem[64]);
        end
        tick();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 7'h41) begin bad++; $display("FAIL redir_next got v=%0d pc=%0d exp 1/65", inst_valid, inst_pc); end
    endtask

    task automatic test_end_of_memory();
        logic [31:0] d;
        for (int i = 0; i < 200 && halted !== 1'b1; i++) tick();
        total++; if (halted !== 1'b1 || inst_valid !== 1'b0 || load_ready !== 1'b1) begin
            bad++; $display("FAIL eom_drain got halted=%0d v=%0d lr=%0d exp 1/0/1", halted, inst_valid, load_ready);
        end
        start = 1'b1; start_addr = 7'd126;
        tick();
        start = 1'b0;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL eom_start_clear got halted=%0d exp=0", halted); end
        tick();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 7'd126 || inst_data !== ref_mem[126]) begin
            bad++; $display("FAIL eom_w126 got v=%0d pc=%0d d=%h exp v=1 pc=126 d=%h", inst_valid, inst_pc, inst_data, ref_mem[126]);
        end
        tick();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 7'd127 || inst_data !== ref_mem[127]) begin
            bad++; $display("FAIL eom_w127 got v=%0d pc=%0d d=%h exp v=1 pc=127 d=%h", inst_valid, inst_pc, inst_data, ref_mem[127]);
        end
        tick();
        total++; if (inst_valid !== 1'b0 || halted !== 1'b1 || load_ready !== 1'b1) begin
            bad++; $display("FAIL eom_halt got v=%0d halted=%0d lr=%0d exp 0/1/1", inst_valid, halted, load_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL eom_nowrap[%0d] got v=%0d pc=%0d exp v=0", i, inst_valid, inst_pc); end
        end
        d = $urandom;
        load_valid = 1'b1; load_addr = 7'd5; load_data = d; start = 1'b1; start_addr = 7'd0;
        tick();
        load_valid = 1'b0; start = 1'b0;
        total++; if (mem_rd !== 1'b0 || mem_addr !== 7'd5 || mem_wdata !== d || load_ready !== 1'b0) begin
            bad++; $display("FAIL loadstart_write got rd=%0d addr=%0d d=%h lr=%0d exp rd=0 addr=5 d=%h lr=0", mem_rd, mem_addr, mem_wdata, load_ready, d);
        end
        ref_mem[5] = d;
        tick();
        total++; if (mem_rd !== 1'b1 || load_ready !== 1'b1) begin bad++; $display("FAIL loadstart_back got rd=%0d lr=%0d exp 1/1", mem_rd, load_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (inst_valid !== 1'b0 || halted !== 1'b1) begin
                bad++; $display("FAIL loadstart_ignored[%0d] got v=%0d halted=%0d exp 0/1", i, inst_valid, halted);
            end
        end
    endtask

    // Stream model: after start/redirect at A, accepted words are A, A+1, ... up to 127, data = loaded contents.
    task automatic test_random();
        int          exp_next;
        bit          active;
        bit          hold_pending;
        logic [6:0]  hold_pc;
        logic [31:0] hold_data;
        int          cyc;
        for (int ep = 0; ep < 4; ep++) begin
            for (int k = 0; k < 4; k++) do_load(7'($urandom_range(0, 127)), $urandom);
            start = 1'b1; start_addr = 7'($urandom_range(40, 127)); inst_ready = 1'b1;
            exp_next = int'(start_addr);
            active = 1; hold_pending = 0;
            tick();
            start = 1'b0;
            cyc = 0;
            while (active && cyc < 2000) begin
                inst_ready     = ($urandom_range(0, 3) != 0);
                redirect_valid = ($urandom_range(0, 15) == 0);
                redirect_addr  = 7'($urandom_range(64, 127));
                total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL rnd_no_write ep=%0d got mem_rd=%0d exp=1", ep, mem_rd); end
                if (hold_pending) begin
                    total++; if (inst_valid !== 1'b1 || inst_pc !== hold_pc || inst_data !== hold_data) begin
                        bad++; $display("FAIL rnd_hold ep=%0d got v=%0d pc=%0d d=%h exp v=1 pc=%0d d=%h", ep, inst_valid, inst_pc, inst_data, hold_pc, hold_data);
                    end
                end
                hold_pending = 0;
                if (redirect_valid) begin
                    exp_next = int'(redirect_addr);
                end else if (inst_valid === 1'b1 && inst_ready) begin
                    total++; if (int'(inst_pc) !== exp_next || inst_data !== ref_mem[exp_next]) begin
                        bad++; $display("FAIL rnd_word ep=%0d got pc=%0d d=%h exp pc=%0d d=%h", ep, inst_pc, inst_data, exp_next, ref_mem[exp_next]);
                    end
                    if (exp_next == 127) active = 0;
                    else exp_next++;
                end else if (inst_valid === 1'b1) begin
                    hold_pending = 1; hold_pc = inst_pc; hold_data = inst_data;
                end
                tick();
                cyc++;
            end
            redirect_valid = 1'b0; inst_ready = 1'b1;
            total++; if (active) begin bad++; $display("FAIL rnd_timeout ep=%0d got next=%0d exp end reached", ep, exp_next); end
            total++; if (halted !== 1'b1 || inst_valid !== 1'b0 || load_ready !== 1'b1) begin
                bad++; $display("FAIL rnd_halt ep=%0d got halted=%0d v=%0d lr=%0d exp 1/0/1", ep, halted, inst_valid, load_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_stall();
        test_redirect();
        test_end_of_memory();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
